// File: rtl/reg_transfer_unit.sv
// reg_transfer_unit
//   Eight-entry register bank with a small command sequencer. All
//   register-to-register traffic goes out through busSel to an external
//   8:1 mux and returns on busIn.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmdValid/cmdReady   command handshake (ready only in IDLE)
//   cmdOp               00 LOAD, 01 MOVE, 10 SWAP, 11 CLEAR
//   cmdSrc, cmdDst      source / destination register index
//   cmdImm              immediate for LOAD
//   busIn               mux output (combinational function of busSel)
//   busSel              mux select
//   outR0..outR7        register contents
//   busy                multi-cycle command in progress
//   done                one-cycle pulse after the final write of a command
module reg_transfer_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [1:0]       cmdOp,
    input  logic [2:0]       cmdSrc,
    input  logic [2:0]       cmdDst,
    input  logic [WIDTH-1:0] cmdImm,
    input  logic [WIDTH-1:0] busIn,
    output logic [2:0]       busSel,
    output logic [WIDTH-1:0] outR0,
    output logic [WIDTH-1:0] outR1,
    output logic [WIDTH-1:0] outR2,
    output logic [WIDTH-1:0] outR3,
    output logic [WIDTH-1:0] outR4,
    output logic [WIDTH-1:0] outR5,
    output logic [WIDTH-1:0] outR6,
    output logic [WIDTH-1:0] outR7,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        XFER   = 3'd1,
        SWAP_A = 3'd2,
        SWAP_B = 3'd3,
        SWAP_C = 3'd4
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_MOVE  = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] tmp_q, tmp_d;
    logic [2:0]       src_q, src_d;
    logic [2:0]       dst_q, dst_d;
    logic             done_q, done_d;

    // Single write port into the bank, shared by every command.
    logic             wr_en;
    logic [2:0]       wr_idx;
    logic [WIDTH-1:0] wr_data;

    logic accept;

    assign cmdReady = (state_q == IDLE);
    assign accept   = cmdValid && cmdReady;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    // Op and immediate are consumed on the accept edge itself (LOAD/CLEAR
    // write immediately, MOVE/SWAP are encoded by the state), so only the
    // register indices need to be held across the multi-cycle sequences.
    always_comb begin
        state_d = state_q;
        tmp_d   = tmp_q;
        src_d   = src_q;
        dst_d   = dst_q;
        done_d  = 1'b0;
        busSel  = 3'd0;
        wr_en   = 1'b0;
        wr_idx  = dst_q;
        wr_data = busIn;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    src_d = cmdSrc;
                    dst_d = cmdDst;
                    unique case (cmdOp)
                        OP_LOAD: begin
                            wr_en   = 1'b1;
                            wr_idx  = cmdDst;
                            wr_data = cmdImm;
                            done_d  = 1'b1;
                        end
                        OP_CLEAR: begin
                            wr_en   = 1'b1;
                            wr_idx  = cmdDst;
                            wr_data = '0;
                            done_d  = 1'b1;
                        end
                        OP_MOVE: state_d = XFER;
                        OP_SWAP: state_d = SWAP_A;
                    endcase
                end
            end
            XFER: begin
                busSel  = src_q;
                wr_en   = 1'b1;
                wr_idx  = dst_q;
                wr_data = busIn;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            SWAP_A: begin
                busSel  = src_q;
                tmp_d   = busIn;
                state_d = SWAP_B;
            end
            SWAP_B: begin
                busSel  = dst_q;
                wr_en   = 1'b1;
                wr_idx  = src_q;
                wr_data = busIn;
                state_d = SWAP_C;
            end
            SWAP_C: begin
                busSel  = dst_q;
                wr_en   = 1'b1;
                wr_idx  = dst_q;
                wr_data = tmp_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmp_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            tmp_q   <= tmp_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            done_q  <= done_d;
            if (wr_en) begin
                regs_q[wr_idx] <= wr_data;
            end
        end
    end

    assign outR0 = regs_q[0];
    assign outR1 = regs_q[1];
    assign outR2 = regs_q[2];
    assign outR3 = regs_q[3];
    assign outR4 = regs_q[4];
    assign outR5 = regs_q[5];
    assign outR6 = regs_q[6];
    assign outR7 = regs_q[7];

endmodule
